// File: rtl/puf_pkg.sv
// Shared constants for the arbiter-PUF challenge/response collector:
// default sizes, LFSR feedback taps and the controller state encodings.
package puf_pkg;

  localparam int DEF_C_LENGTH  = 8;
  localparam int DEF_N_EVAL    = 7;
  localparam int DEF_RESP_BITS = 8;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 (bit i-1 set for term x^i)
  localparam logic [7:0] LFSR_TAPS_8 = 8'hB8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_FIRE   = 3'd2;
  localparam logic [2:0] ST_SYNC1  = 3'd3;
  localparam logic [2:0] ST_SYNC2  = 3'd4;
  localparam logic [2:0] ST_SAMPLE = 3'd5;

  function automatic logic [63:0] lfsr_taps(input int len);
    case (len)
      4:       return 64'hC;
      8:       return {56'd0, LFSR_TAPS_8};
      16:      return 64'hB400;
      default: return 64'd3 << (len - 2);
    endcase
  endfunction

endpackage

// File: rtl/puf_crp_collector_if.sv
// Host and PUF-side signal bundle of the collector; master is the host/PUF
// environment, slave is the collector itself.
interface puf_crp_collector_if import puf_pkg::*; #(
  parameter int C_LENGTH  = DEF_C_LENGTH,
  parameter int RESP_BITS = DEF_RESP_BITS
);
  localparam int UW = $clog2(RESP_BITS + 1);

  // Handshake: start is a one-cycle request honoured only while the collector
  // is idle and not pulsing done; done is a one-cycle pulse that marks
  // resp_word/unstable_cnt as updated, and they hold until the next done.
  logic                 start;
  logic [C_LENGTH-1:0]  seed;
  logic                 busy;
  logic                 done;
  logic [RESP_BITS-1:0] resp_word;
  logic [UW-1:0]        unstable_cnt;
  logic [C_LENGTH-1:0]  puf_challenge;
  logic                 puf_pulse;
  logic                 puf_response;

  modport master (
    output start, seed, puf_response,
    input  busy, done, resp_word, unstable_cnt, puf_challenge, puf_pulse
  );

  modport slave (
    input  start, seed, puf_response,
    output busy, done, resp_word, unstable_cnt, puf_challenge, puf_pulse
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous arbiter response.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/puf_crp_collector.sv
// Drives challenge/launch pulses into the arbiter PUF, majority-votes each
// response bit over N_EVAL evaluations and packs RESP_BITS bits per word.
module puf_crp_collector import puf_pkg::*; #(
  parameter int C_LENGTH  = DEF_C_LENGTH,
  parameter int N_EVAL    = DEF_N_EVAL,
  parameter int RESP_BITS = DEF_RESP_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  puf_crp_collector_if.slave  bus,
  output logic [2:0]          state_dbg
);
  localparam int OW = $clog2(N_EVAL + 1);
  localparam int BW = $clog2(RESP_BITS + 1);
  localparam logic [C_LENGTH-1:0] TAPS = C_LENGTH'(lfsr_taps(C_LENGTH));

  logic [2:0]           state;
  logic [OW-1:0]        ones_cnt;
  logic [OW-1:0]        eval_idx;
  logic [BW-1:0]        bit_idx;
  logic [BW-1:0]        unst;
  logic [RESP_BITS-1:0] shreg;
  logic [C_LENGTH-1:0]  lfsr;
  logic                 pulse_q;
  logic                 busy_q;
  logic                 done_q;
  logic [RESP_BITS-1:0] word_q;
  logic [BW-1:0]        unst_q;
  logic                 resp_sync;

  logic [OW-1:0]        ones_final;
  logic                 vote;
  logic                 bit_unstable;
  logic                 eval_last;
  logic                 bit_last;
  logic                 accept;
  logic [C_LENGTH-1:0]  lfsr_next;
  logic [RESP_BITS-1:0] shreg_next;
  logic [BW-1:0]        unst_next;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.puf_response),
    .q     (resp_sync)
  );

  // ones_final already includes the sample arriving in the current SAMPLE cycle
  always_comb begin
    ones_final   = ones_cnt + OW'(resp_sync);
    vote         = (ones_final > OW'(N_EVAL / 2));
    bit_unstable = (ones_final != '0) && (ones_final != OW'(N_EVAL));
    eval_last    = (eval_idx == OW'(N_EVAL - 1));
    bit_last     = (bit_idx == BW'(RESP_BITS - 1));
    lfsr_next    = {lfsr[C_LENGTH-2:0], ^(lfsr & TAPS)};
    shreg_next   = (shreg << 1) | RESP_BITS'(vote);
    unst_next    = unst + BW'(bit_unstable);
    // a start coinciding with the done pulse is dropped
    accept       = (state == ST_IDLE) && bus.start && !done_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ones_cnt <= '0;
      eval_idx <= '0;
      bit_idx  <= '0;
      unst     <= '0;
      shreg    <= '0;
      lfsr     <= '0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      word_q   <= '0;
      unst_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            // all-zero seed would lock the LFSR
            lfsr     <= (bus.seed == '0) ? C_LENGTH'(1) : bus.seed;
            ones_cnt <= '0;
            eval_idx <= '0;
            bit_idx  <= '0;
            unst     <= '0;
            shreg    <= '0;
            busy_q   <= 1'b1;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          pulse_q <= 1'b1;
          state   <= ST_FIRE;
        end
        ST_FIRE: begin
          pulse_q <= 1'b0;
          state   <= ST_SYNC1;
        end
        ST_SYNC1: state <= ST_SYNC2;
        ST_SYNC2: state <= ST_SAMPLE;
        ST_SAMPLE: begin
          if (!eval_last) begin
            ones_cnt <= ones_final;
            eval_idx <= eval_idx + OW'(1);
            state    <= ST_SETUP;
          end else begin
            ones_cnt <= '0;
            eval_idx <= '0;
            shreg    <= shreg_next;
            unst     <= unst_next;
            if (bit_last) begin
              // challenge stays put so it only moves on SAMPLE->SETUP
              word_q <= shreg_next;
              unst_q <= unst_next;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              bit_idx <= bit_idx + BW'(1);
              lfsr    <= lfsr_next;
              state   <= ST_SETUP;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.resp_word     = word_q;
  assign bus.unstable_cnt  = unst_q;
  assign bus.puf_challenge = lfsr;
  assign bus.puf_pulse     = pulse_q;
  assign state_dbg         = state;
endmodule

// File: doc/puf_crp_collector.md
# puf_crp_collector

Challenge-response controller that sits directly upstream and downstream of the 8-stage arbiter PUF. It drives the PUF's challenge bus and launch pulse, then captures the asynchronous arbiter response through a 2-flop synchronizer. Each response bit is majority-voted over N_EVAL evaluations, and RESP_BITS bits are packed into one response word. Successive challenges come from an LFSR seeded by the host, and the collector also counts unstable (disagreeing) bits.

## Interface
Parameters:
- C_LENGTH, 8: challenge width; must match the PUF mux-chain length.
- N_EVAL, 7: evaluations per response bit; odd, range 1..15.
- RESP_BITS, 8: response bits per word, range 1..16.

Ports:
- clk  in  1  single clock. Also the source domain of puf_pulse.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request. Sampled only in IDLE.
- seed  in  C_LENGTH  first challenge, latched on accepted start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when resp_word is updated.
- resp_word  out  RESP_BITS  packed voted response. The first bit ends up in the MSB. Held until the next done.
- unstable_cnt  out  clog2(RESP_BITS+1)  number of bits in the last word whose evaluations disagreed.
- puf_challenge  out  C_LENGTH  registered challenge driven to the PUF.
- puf_pulse  out  1  registered launch pulse driven to the PUF.
- puf_response  in  1  arbiter output, asynchronous to clk.

## Operation
- FSM states and transitions:
  - IDLE
  - SETUP: puf_pulse=0, challenge stable.
  - FIRE: puf_pulse=1.
  - SYNC1, SYNC2: synchronizer settling.
  - SAMPLE: add the synchronized response to ones_cnt.
  - SETUP follows SAMPLE, or the FSM goes to IDLE after the last sample.
- Accepted start (IDLE & start):
  - Latch seed into the LFSR; a seed of all-zero is replaced with 1 (LFSR lockup avoidance).
  - Clear ones_cnt, bit_idx and the unstable counter.
  - Go to SETUP.
- SAMPLE with eval_idx < N_EVAL-1: increment eval_idx, go to SETUP. The challenge is unchanged.
- SAMPLE with eval_idx = N_EVAL-1, i.e. the bit is complete:
  - vote = (ones_cnt_final > N_EVAL/2).
  - Shift vote into the word shift register from the LSB side.
  - If ones_cnt_final is neither 0 nor N_EVAL, increment the unstable counter.
  - Clear ones_cnt and eval_idx.
  - Advance the LFSR one step: Fibonacci, taps x^8+x^6+x^5+x^4+1 for C_LENGTH=8, shift left, feedback into the LSB.
- Last bit of the word (bit_idx = RESP_BITS-1):
  - Copy the shift register to resp_word and the counter to unstable_cnt.
  - Pulse done, return to IDLE.
- start while busy is ignored. There is no queueing.
- ones_cnt width is clog2(N_EVAL+1) and cannot overflow.

## Timing
- Reset values: busy=0, done=0, resp_word=0, unstable_cnt=0, puf_challenge=0, puf_pulse=0, synchronizer flops=0, FSM=IDLE.
- Reset asserted mid-operation aborts immediately: outputs take reset values, no done, and resp_word reverts to 0.
- Start accepted at edge T: busy=1 and puf_challenge=seed visible after edge T. SETUP occupies cycle T+1.
- Each evaluation is 5 cycles: SETUP, FIRE, SYNC1, SYNC2, SAMPLE. The puf_pulse high time is exactly 1 cycle, with at least 4 low cycles between rising edges.
- puf_challenge changes only on the SAMPLE→SETUP transition at a bit boundary. It is never changed while puf_pulse=1.
- done is asserted in cycle T+5·N_EVAL·RESP_BITS+1, i.e. cycle T+281 with defaults. busy drops in the same cycle.
- A new start is accepted in the cycle after done at the earliest.

## Structure
- Shared package puf_pkg:
  - FSM state enum.
  - LFSR tap constant LFSR_TAPS_8 = 8'hB8.
  - Default parameter constants.
- One sub-module, sync2: 2-flop synchronizer with asynchronous active-low reset, used on puf_response.
- The LFSR and vote logic stay inline in the controller.

## Test plan
- puf_response tied 1, seed 8'hA5, start → done at T+281; resp_word=8'hFF, unstable_cnt=0; puf_challenge sequence matches the LFSR reference model from 8'hA5.
- puf_response tied 0, seed 8'h00 → first challenge is 8'h01; resp_word=8'h00, unstable_cnt=0.
- Response model returns challenge[0] for evaluations 0..3 and ~challenge[0] for evaluations 4..6 → resp_word equals the challenge[0] bits in order; unstable_cnt=8.
- start pulsed again mid-word and on done+0 → ignored; exactly one done per accepted start; the word is unaffected.
- rst_n asserted at cycle T+100 → all outputs at reset values in the same cycle; a fresh start after release produces a correct word and timing.
- Pulse checker, all runs → puf_pulse high for exactly 1 cycle; 56 pulses per word with defaults; no challenge change while puf_pulse=1.
